// File: rtl/div_seq_pkg.sv
// Shared widths, FSM state encodings and control constants for the sequential divider.
package div_seq_pkg;

    localparam int DivDataW = 32;
    localparam int DivCntW  = 6;

    typedef logic [DivDataW-1:0]   RegBus;
    typedef logic [2*DivDataW-1:0] DoubleRegBus;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } divState_t;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the EX stage (master) and the iterative divider (slave).
interface div_seq_if
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DivDataW
) ();

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );

endinterface

// File: rtl/div_seq.sv
// Multi-cycle shift/subtract divider: 32 restoring steps on magnitudes, sign fix-up on the
// final step, {remainder, quotient} registered with a one-cycle ready pulse.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DivDataW,
    parameter int CNT_W  = DivCntW
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);

    divState_t             r_state;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_dvd;
    logic [DATA_W-1:0]     r_quot;
    logic [DATA_W-1:0]     r_divisor;
    logic                  r_negQuot;
    logic                  r_negRem;
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    logic [DATA_W-1:0]     w_absA;
    logic [DATA_W-1:0]     w_absB;
    logic [DATA_W:0]       w_shifted;
    logic                  w_noBorrow;
    logic [DATA_W-1:0]     w_diff;
    logic [DATA_W-1:0]     w_remNext;
    logic [DATA_W-1:0]     w_quotNext;
    logic [DATA_W-1:0]     w_remFinal;
    logic [DATA_W-1:0]     w_quotFinal;

    assign w_absA = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign w_absB = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // The partial remainder stays below the divisor, so the true difference always fits in
    // DATA_W bits and only the comparison needs the extra shifted-out bit.
    assign w_shifted   = {r_rem, r_dvd[DATA_W-1]};
    assign w_noBorrow  = (w_shifted >= {1'b0, r_divisor});
    assign w_diff      = w_shifted[DATA_W-1:0] - r_divisor;
    assign w_remNext   = w_noBorrow ? w_diff : w_shifted[DATA_W-1:0];
    assign w_quotNext  = {r_quot[DATA_W-2:0], w_noBorrow};
    assign w_quotFinal = r_negQuot ? -w_quotNext : w_quotNext;
    assign w_remFinal  = r_negRem ? -w_remNext : w_remNext;

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DivFree;
            r_count   <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
            r_result  <= '0;
            r_ready   <= DivResultNotReady;
        end else begin
            r_ready <= DivResultNotReady;
            unique case (r_state)
                DivFree: begin
                    if (!bus.annul_i && bus.start_i == DivStart) begin
                        if (bus.opdata2_i == '0) begin
                            r_state <= DivByZero;
                        end else begin
                            r_dvd     <= w_absA;
                            r_divisor <= w_absB;
                            r_rem     <= '0;
                            r_quot    <= '0;
                            r_count   <= '0;
                            r_negQuot <= bus.signed_div_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                            r_negRem  <= bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                            r_state   <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    if (bus.annul_i) begin
                        r_state <= DivFree;
                    end else begin
                        r_result <= '0;
                        r_ready  <= DivResultReady;
                        r_state  <= DivEnd;
                    end
                end
                DivOn: begin
                    if (bus.annul_i) begin
                        r_state <= DivFree;
                    end else begin
                        r_rem   <= w_remNext;
                        r_quot  <= w_quotNext;
                        r_dvd   <= {r_dvd[DATA_W-2:0], 1'b0};
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(DATA_W-1)) begin
                            r_result <= {w_remFinal, w_quotFinal};
                            r_ready  <= DivResultReady;
                            r_state  <= DivEnd;
                        end
                    end
                end
                DivEnd: begin
                    r_state <= DivFree;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide-by-zero, annul,
// back-to-back requests and mid-operation reset.
module tb_div_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_seq_if #(.DATA_W(32)) bus ();

    div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady(output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (bus.ready_o !== 1'b1 && edges < 100);
    endtask

    task automatic setOp(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready got %0b want 0", bus.ready_o);
        end
        checks++;
        if (bus.result_o !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_result got %h want 0", bus.result_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int n;
        setOp(1'b0, 32'd100, 32'd7);
        tick();
        waitReady(n);
        checks++;
        if (n != 32) begin
            errors++;
            $display("[TB] FAIL unsigned_latency got %0d want 32", n);
        end
        checks++;
        if (bus.result_o !== {32'd2, 32'd14}) begin
            errors++;
            $display("[TB] FAIL unsigned_100_7 got %h want %h", bus.result_o, {32'd2, 32'd14});
        end
        bus.start_i = 1'b0;
        tick();
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_pulse_width got %0b want 0", bus.ready_o);
        end
        checks++;
        if (bus.result_o !== {32'd2, 32'd14}) begin
            errors++;
            $display("[TB] FAIL result_hold got %h want %h", bus.result_o, {32'd2, 32'd14});
        end
        tick();
    endtask

    task automatic test_signed();
        int n;
        setOp(1'b1, 32'hFFFF_FFF9, 32'd2);
        tick();
        waitReady(n);
        bus.start_i = 1'b0;
        checks++;
        if (bus.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            errors++;
            $display("[TB] FAIL signed_m7_2 got %h want %h", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("[TB] FAIL signed_latency got %0d want 32", n);
        end
        tick();
        setOp(1'b1, 32'd7, 32'hFFFF_FFFE);
        tick();
        waitReady(n);
        bus.start_i = 1'b0;
        checks++;
        if (bus.result_o !== {32'd1, 32'hFFFF_FFFD}) begin
            errors++;
            $display("[TB] FAIL signed_7_m2 got %h want %h", bus.result_o, {32'd1, 32'hFFFF_FFFD});
        end
        tick();
    endtask

    task automatic test_divzero();
        int n;
        setOp(1'b0, 32'd55, 32'd0);
        tick();
        waitReady(n);
        bus.start_i = 1'b0;
        checks++;
        if (n != 1) begin
            errors++;
            $display("[TB] FAIL divzero_latency got %0d want 1", n);
        end
        checks++;
        if (bus.result_o !== 64'h0) begin
            errors++;
            $display("[TB] FAIL divzero_result got %h want 0", bus.result_o);
        end
        tick();
    endtask

    task automatic test_overflow();
        int n;
        setOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        waitReady(n);
        bus.start_i = 1'b0;
        checks++;
        if (bus.result_o !== {32'h0, 32'h8000_0000}) begin
            errors++;
            $display("[TB] FAIL signed_overflow got %h want %h", bus.result_o, {32'h0, 32'h8000_0000});
        end
        tick();
        setOp(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        waitReady(n);
        bus.start_i = 1'b0;
        checks++;
        if (bus.result_o !== {32'h8000_0000, 32'h0}) begin
            errors++;
            $display("[TB] FAIL unsigned_big got %h want %h", bus.result_o, {32'h8000_0000, 32'h0});
        end
        tick();
    endtask

    task automatic test_annul();
        int n;
        int seen;
        seen = 0;
        setOp(1'b0, 32'd1000, 32'd9);
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.ready_o === 1'b1) seen++;
        end
        bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        if (bus.ready_o === 1'b1) seen++;
        tick();
        if (bus.ready_o === 1'b1) seen++;
        checks++;
        if (bus.result_o !== {32'h8000_0000, 32'h0}) begin
            errors++;
            $display("[TB] FAIL annul_result_kept got %h want %h", bus.result_o, {32'h8000_0000, 32'h0});
        end
        setOp(1'b0, 32'd20, 32'd3);
        tick();
        waitReady(n);
        bus.start_i = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL annul_no_ready got %0d pulses want 0", seen);
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("[TB] FAIL after_annul_latency got %0d want 32", n);
        end
        checks++;
        if (bus.result_o !== {32'd2, 32'd6}) begin
            errors++;
            $display("[TB] FAIL after_annul_20_3 got %h want %h", bus.result_o, {32'd2, 32'd6});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        setOp(1'b0, 32'd50, 32'd5);
        tick();
        waitReady(n);
        checks++;
        if (bus.result_o !== {32'd0, 32'd10}) begin
            errors++;
            $display("[TB] FAIL b2b_first got %h want %h", bus.result_o, {32'd0, 32'd10});
        end
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd4;
        tick();
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_done_to_idle got ready %0b want 0", bus.ready_o);
        end
        waitReady(n);
        bus.start_i = 1'b0;
        checks++;
        if (n != 33) begin
            errors++;
            $display("[TB] FAIL b2b_latency got %0d want 33", n);
        end
        checks++;
        if (bus.result_o !== {32'd1, 32'd2}) begin
            errors++;
            $display("[TB] FAIL b2b_9_4 got %h want %h", bus.result_o, {32'd1, 32'd2});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        setOp(1'b0, 32'd77, 32'd5);
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_ready got %0b want 0", bus.ready_o);
        end
        checks++;
        if (bus.result_o !== 64'h0) begin
            errors++;
            $display("[TB] FAIL midreset_result got %h want 0", bus.result_o);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ready_o === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL midreset_work_discarded got %0d pulses want 0", seen);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_overflow();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
